// File: rtl/vga2_fetchz_if.sv
// Pixel, Z line-buffer and Z-check stage signal bundle for vga2_fetchz.
// The slave view belongs to the fetch stage; the master view belongs to its surroundings.
interface vga2_fetchz_if;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_x;
  logic [11:0] in_z;
  logic [11:0] in_u;
  logic [11:0] in_v;
  logic [4:0]  in_mode;
  logic [31:0] in_src_addr;
  logic [31:0] in_src_stride;

  logic        zbuf_rd_en;
  logic [9:0]  zbuf_rd_addr;
  logic [11:0] zbuf_rd_data;

  logic        zbuf_wr_en;
  logic [9:0]  zbuf_wr_addr;
  logic [11:0] zbuf_wr_data;

  logic        chkz_ready;
  logic        chkz_valid;
  logic [9:0]  chkz_x;
  logic [11:0] chkz_z;
  logic [11:0] chkz_u;
  logic [11:0] chkz_v;
  logic [4:0]  chkz_mode;
  logic [31:0] chkz_src_addr;
  logic [31:0] chkz_src_stride;
  logic [11:0] fetched_z;

  modport slave (
    input  in_valid, in_x, in_z, in_u, in_v, in_mode, in_src_addr, in_src_stride,
    output in_ready,
    output zbuf_rd_en, zbuf_rd_addr,
    input  zbuf_rd_data,
    input  zbuf_wr_en, zbuf_wr_addr, zbuf_wr_data,
    input  chkz_ready,
    output chkz_valid, chkz_x, chkz_z, chkz_u, chkz_v, chkz_mode,
    output chkz_src_addr, chkz_src_stride, fetched_z
  );

  modport master (
    output in_valid, in_x, in_z, in_u, in_v, in_mode, in_src_addr, in_src_stride,
    input  in_ready,
    input  zbuf_rd_en, zbuf_rd_addr,
    output zbuf_rd_data,
    output zbuf_wr_en, zbuf_wr_addr, zbuf_wr_data,
    output chkz_ready,
    input  chkz_valid, chkz_x, chkz_z, chkz_u, chkz_v, chkz_mode,
    input  chkz_src_addr, chkz_src_stride, fetched_z
  );
endinterface

// File: rtl/vga2_fetchz.sv
// Z fetch stage: reads the Z line buffer at in_x and pairs the result with the pixel in a 2-entry FIFO.
// Define VGA2_FETCHZ_BYPASS_EN to forward snooped Z write-backs into pending and buffered pixels.
module vga2_fetchz (
  input logic          clock,
  input logic          reset,
  vga2_fetchz_if.slave bus
);

  logic [1:0]  occ_r;
  logic        wr_ptr_r;
  logic        rd_ptr_r;
  logic        pend_valid_r;
  logic        pend_idx_r;
  logic        accept_s;
  logic        deliver_s;
  logic [11:0] fresh_z_s;
  logic [1:0]  hit_s;

  logic [9:0]  fifo_x_r      [2];
  logic [11:0] fifo_z_r      [2];
  logic [11:0] fifo_u_r      [2];
  logic [11:0] fifo_v_r      [2];
  logic [4:0]  fifo_mode_r   [2];
  logic [31:0] fifo_addr_r   [2];
  logic [31:0] fifo_stride_r [2];
  logic [11:0] fifo_fz_r     [2];

  assign bus.in_ready   = (occ_r < 2'd2) && !reset;
  assign bus.chkz_valid = (occ_r != 2'd0);
  assign accept_s       = bus.in_valid && bus.in_ready;
  assign deliver_s      = bus.chkz_valid && bus.chkz_ready;

  // Line-buffer read is issued in the accept cycle itself.
  always_comb begin
    bus.zbuf_rd_en   = 1'b0;
    bus.zbuf_rd_addr = 10'd0;
    if (accept_s) begin
      bus.zbuf_rd_en   = 1'b1;
      bus.zbuf_rd_addr = bus.in_x;
    end else begin
      bus.zbuf_rd_en   = 1'b0;
      bus.zbuf_rd_addr = 10'd0;
    end
  end

`ifdef VGA2_FETCHZ_BYPASS_EN
  logic [1:0] entry_valid_s;

  // Forward a colliding write-back into the returning read and into every buffered entry.
  always_comb begin
    fresh_z_s     = bus.zbuf_rd_data;
    entry_valid_s = (occ_r == 2'd2) ? 2'b11 :
                    (occ_r == 2'd1) ? (rd_ptr_r ? 2'b10 : 2'b01) : 2'b00;
    if (bus.zbuf_wr_en && (bus.zbuf_wr_addr == fifo_x_r[pend_idx_r])) begin
      fresh_z_s = bus.zbuf_wr_data;
    end else begin
      fresh_z_s = bus.zbuf_rd_data;
    end
    for (int i = 0; i < 2; i++) begin
      hit_s[i] = bus.zbuf_wr_en && entry_valid_s[i] && (fifo_x_r[i] == bus.zbuf_wr_addr);
    end
  end
`else
  // Returned Z is used exactly as read; write-backs are not observed.
  always_comb begin
    fresh_z_s = bus.zbuf_rd_data;
    hit_s     = 2'b00;
  end
`endif

  // Occupancy, FIFO pointers and the one-cycle read-return tracker.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occ_r        <= 2'd0;
      wr_ptr_r     <= 1'b0;
      rd_ptr_r     <= 1'b0;
      pend_valid_r <= 1'b0;
      pend_idx_r   <= 1'b0;
    end else begin
      occ_r        <= occ_r + {1'b0, accept_s} - {1'b0, deliver_s};
      wr_ptr_r     <= accept_s ? ~wr_ptr_r : wr_ptr_r;
      rd_ptr_r     <= deliver_s ? ~rd_ptr_r : rd_ptr_r;
      pend_valid_r <= accept_s;
      pend_idx_r   <= wr_ptr_r;
    end
  end

  // FIFO payload; fields land at accept, fetched Z lands when the read returns.
  always_ff @(posedge clock) begin
    if (accept_s) begin
      fifo_x_r[wr_ptr_r]      <= bus.in_x;
      fifo_z_r[wr_ptr_r]      <= bus.in_z;
      fifo_u_r[wr_ptr_r]      <= bus.in_u;
      fifo_v_r[wr_ptr_r]      <= bus.in_v;
      fifo_mode_r[wr_ptr_r]   <= bus.in_mode;
      fifo_addr_r[wr_ptr_r]   <= bus.in_src_addr;
      fifo_stride_r[wr_ptr_r] <= bus.in_src_stride;
    end
    for (int i = 0; i < 2; i++) begin
      if (pend_valid_r && (pend_idx_r == 1'(i))) begin
        fifo_fz_r[i] <= fresh_z_s;
      end else if (hit_s[i]) begin
        fifo_fz_r[i] <= bus.zbuf_wr_data;
      end
    end
  end

  // Head view; a head whose read is still returning shows the live read data.
  always_comb begin
    bus.chkz_x          = fifo_x_r[rd_ptr_r];
    bus.chkz_z          = fifo_z_r[rd_ptr_r];
    bus.chkz_u          = fifo_u_r[rd_ptr_r];
    bus.chkz_v          = fifo_v_r[rd_ptr_r];
    bus.chkz_mode       = fifo_mode_r[rd_ptr_r];
    bus.chkz_src_addr   = fifo_addr_r[rd_ptr_r];
    bus.chkz_src_stride = fifo_stride_r[rd_ptr_r];
    bus.fetched_z       = fifo_fz_r[rd_ptr_r];
    if (pend_valid_r && (pend_idx_r == rd_ptr_r)) begin
      bus.fetched_z = fresh_z_s;
    end else begin
      bus.fetched_z = fifo_fz_r[rd_ptr_r];
    end
  end

endmodule

// File: tb/tb_vga2_fetchz.sv
// Directed bench for vga2_fetchz with a Z line-buffer model and an in-order scoreboard.
module tb_vga2_fetchz;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  vga2_fetchz_if bus ();
  vga2_fetchz dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct {
    logic [9:0]  x;
    logic [11:0] z;
    logic [11:0] u;
    logic [11:0] v;
    logic [4:0]  mode;
    logic [31:0] addr;
    logic [31:0] stride;
    logic [11:0] fz;
  } pix_t;

  logic [11:0] zmem [1024];
  pix_t        sb [$];
  pix_t        mon_e;
  int          compared   = 0;
  int          mismatched = 0;
  int          delivered  = 0;
  int          d0;
  logic [11:0] exp_bp;

  // Line buffer: data valid one cycle after the read enable.
  always @(posedge clock) begin
    if (bus.zbuf_rd_en === 1'b1) bus.zbuf_rd_data <= zmem[bus.zbuf_rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic pix_t mk(input logic [9:0] x);
    pix_t p;
    p.x      = x;
    p.z      = {2'b00, x} + 12'h100;
    p.u      = {2'b00, x} ^ 12'hA5A;
    p.v      = 12'hFFF - {2'b00, x};
    p.mode   = x[4:0] ^ 5'h15;
    p.addr   = 32'h1000_0000 + {22'd0, x};
    p.stride = 32'd640 + {22'd0, x};
    p.fz     = zmem[x];
    return p;
  endfunction

  task automatic offer(input logic [9:0] x);
    pix_t p;
    p = mk(x);
    bus.in_valid      = 1'b1;
    bus.in_x          = p.x;
    bus.in_z          = p.z;
    bus.in_u          = p.u;
    bus.in_v          = p.v;
    bus.in_mode       = p.mode;
    bus.in_src_addr   = p.addr;
    bus.in_src_stride = p.stride;
  endtask

  // Output monitor: every delivered pixel must match the scoreboard head.
  always @(negedge clock) begin
    if (!reset && bus.chkz_valid === 1'b1 && bus.chkz_ready === 1'b1) begin
      delivered++;
      if (sb.size() == 0) begin
        check("out_without_expected", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        check("out_x",      32'(bus.chkz_x),         32'(mon_e.x));
        check("out_z",      32'(bus.chkz_z),         32'(mon_e.z));
        check("out_u",      32'(bus.chkz_u),         32'(mon_e.u));
        check("out_v",      32'(bus.chkz_v),         32'(mon_e.v));
        check("out_mode",   32'(bus.chkz_mode),      32'(mon_e.mode));
        check("out_addr",   bus.chkz_src_addr,       mon_e.addr);
        check("out_stride", bus.chkz_src_stride,     mon_e.stride);
        check("out_fz",     32'(bus.fetched_z),      32'(mon_e.fz));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    for (int i = 0; i < 1024; i++) zmem[i] = 12'(i * 37 + 5);
    bus.in_valid = 1'b0; bus.in_x = 10'd0; bus.in_z = 12'd0; bus.in_u = 12'd0; bus.in_v = 12'd0;
    bus.in_mode = 5'd0; bus.in_src_addr = 32'd0; bus.in_src_stride = 32'd0;
    bus.zbuf_wr_en = 1'b0; bus.zbuf_wr_addr = 10'd0; bus.zbuf_wr_data = 12'd0;
    bus.chkz_ready = 1'b0;

    // Reset holds everything idle even with a pixel offered.
    offer(10'd5);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready",   32'(bus.in_ready),   32'd0);
    check("rst_chkz_valid", 32'(bus.chkz_valid), 32'd0);
    check("rst_rd_en",      32'(bus.zbuf_rd_en), 32'd0);

    // Single pixel: read issued same cycle, result one cycle later.
    @(posedge clock); #1;
    reset = 1'b0;
    zmem[5] = 12'h300;
    bus.chkz_ready = 1'b1;
    offer(10'd5);
    @(negedge clock);
    check("single_in_ready", 32'(bus.in_ready),     32'd1);
    check("single_rd_en",    32'(bus.zbuf_rd_en),   32'd1);
    check("single_rd_addr",  32'(bus.zbuf_rd_addr), 32'd5);
    sb.push_back(mk(10'd5));
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    @(negedge clock);
    check("single_valid", 32'(bus.chkz_valid), 32'd1);
    check("single_x",     32'(bus.chkz_x),     32'd5);
    check("single_fz",    32'(bus.fetched_z),  32'h300);
    @(posedge clock); #1;

    // Back-to-back stream x=0..9 with the consumer always ready.
    d0 = delivered;
    for (int i = 0; i < 10; i++) begin
      offer(10'(i));
      @(negedge clock);
      check("stream_in_ready", 32'(bus.in_ready), 32'd1);
      if (i > 0) check("stream_valid", 32'(bus.chkz_valid), 32'd1);
      sb.push_back(mk(10'(i)));
      @(posedge clock); #1;
    end
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clock); #1;
    check("stream_count", 32'(delivered - d0), 32'd10);

    // Stalled consumer: two accepted, third blocked until space frees.
    bus.chkz_ready = 1'b0;
    offer(10'd20);
    @(negedge clock);
    check("stall_acc0", 32'(bus.in_ready), 32'd1);
    sb.push_back(mk(10'd20));
    @(posedge clock); #1;
    offer(10'd21);
    @(negedge clock);
    check("stall_acc1", 32'(bus.in_ready), 32'd1);
    sb.push_back(mk(10'd21));
    @(posedge clock); #1;
    offer(10'd22);
    @(negedge clock);
    check("stall_block", 32'(bus.in_ready), 32'd0);
    check("stall_head",  32'(bus.chkz_x),   32'd20);
    @(posedge clock); #1;
    bus.chkz_ready = 1'b1;
    @(negedge clock);
    check("stall_release_full", 32'(bus.in_ready), 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    check("stall_third_acc", 32'(bus.in_ready), 32'd1);
    sb.push_back(mk(10'd22));
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clock); #1;
    check("stall_drained", 32'(sb.size()), 32'd0);

    // Write-back snoop on a stalled head.
    bus.chkz_ready = 1'b0;
    zmem[7] = 12'h400;
    offer(10'd7);
    @(negedge clock);
    sb.push_back(mk(10'd7));
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    @(negedge clock);
    check("bp_before", 32'(bus.fetched_z), 32'h400);
    @(posedge clock); #1;
    bus.zbuf_wr_en = 1'b1; bus.zbuf_wr_addr = 10'd7; bus.zbuf_wr_data = 12'h100;
    @(negedge clock);
    check("bp_same_cycle", 32'(bus.fetched_z), 32'h400);
    @(posedge clock); #1;
    bus.zbuf_wr_en = 1'b0;
`ifdef VGA2_FETCHZ_BYPASS_EN
    exp_bp = 12'h100;
`else
    exp_bp = 12'h400;
`endif
    @(negedge clock);
    check("bp_after", 32'(bus.fetched_z), 32'(exp_bp));
    sb[0].fz = exp_bp;
    @(posedge clock); #1;
    bus.chkz_ready = 1'b1;
    repeat (3) @(posedge clock); #1;

    // Reset with a full FIFO and a read still returning.
    bus.chkz_ready = 1'b0;
    offer(10'd30);
    @(negedge clock);
    sb.push_back(mk(10'd30));
    @(posedge clock); #1;
    offer(10'd31);
    @(negedge clock);
    sb.push_back(mk(10'd31));
    @(posedge clock); #1;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    sb.delete();
    @(negedge clock);
    check("midrst_valid",    32'(bus.chkz_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready),   32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    bus.chkz_ready = 1'b1;
    d0 = delivered;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("postrst_idle", 32'(bus.chkz_valid), 32'd0);
    end
    check("postrst_no_out", 32'(delivered - d0), 32'd0);
    @(posedge clock); #1;
    offer(10'd40);
    @(negedge clock);
    check("postrst_acc", 32'(bus.in_ready), 32'd1);
    sb.push_back(mk(10'd40));
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clock); #1;
    check("final_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
